ula_operand_loader: RTL

//   Upstream operand-entry stage for the 16-bit ULA on the Basys3 board.

---
 rtl/ula_operand_loader_if.sv | 32 +++
 rtl/ula_operand_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ula_operand_loader_if.sv
// Operand-loader bus: switch/button inputs toward the loader and the
// registered operand set toward the ULA.
//   sw        slide switches (asynchronous to clk)
//   btn_enter raw enter button (asynchronous)
//   btn_clear raw clear button (asynchronous)
//   A, B, op  operands / opcode driven to the ULA
//   valid     1 while a complete operand set is loaded
//   state     FSM state code for LEDs
// master = board/stimulus side, slave = the loader.
interface ula_operand_loader_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
);
  logic [WIDTH-1:0] sw;
  logic             btn_enter;
  logic             btn_clear;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   op;
  logic             valid;
  logic [1:0]       state;

  modport master (
    output sw, btn_enter, btn_clear,
    input  A, B, op, valid, state
  );

  modport slave (
    input  sw, btn_enter, btn_clear,
    output A, B, op, valid, state
  );
endinterface

// File: rtl/ula_operand_loader.sv
// Operand-entry stage for the 16-bit ULA.
// Synchronises the switches and two buttons, debounces the buttons, and
// walks A -> B -> op on each enter press. valid marks a complete set.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ula_operand_loader_if.slave (sw/buttons in, A/B/op/valid/state out)

// One debouncer lane: accepts a new level only after it has been stable
// for DEBOUNCE_CYCLES consecutive cycles, and emits a one-cycle press
// pulse on each accepted rising level.
module ula_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,     // already synchronised
  output logic level,   // debounced level
  output logic press    // one-cycle pulse on debounced rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      level_q <= level;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // stable long enough: accept the new level
        level <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module ula_operand_loader #(
  parameter int WIDTH           = 16,
  parameter int OPW             = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                 clk,
  input logic                 rst,
  ula_operand_loader_if.slave bus
);
  localparam int NUM_BTN = 2;   // [0]=enter, [1]=clear

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    READY   = 2'b11
  } st_t;

  // 2-FF synchronisers
  logic [WIDTH-1:0]   sw_s1, sw_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= bus.sw;
      sw_s2  <= sw_s1;
      btn_s1 <= {bus.btn_clear, bus.btn_enter};
      btn_s2 <= btn_s1;
    end
  end

  // debouncer lanes
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_press;

  ula_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_s2),
    .level (btn_lvl),
    .press (btn_press)
  );

  logic enter_p, clear_p;
  assign enter_p = btn_press[0];
  assign clear_p = btn_press[1];

  // FSM + operand registers
  st_t              st, st_nxt;
  logic [WIDTH-1:0] a_r, b_r, a_nxt, b_nxt;
  logic [OPW-1:0]   op_r, op_nxt;
  logic             valid_r, valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= LOAD_A;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      valid_r <= 1'b0;
    end else begin
      st      <= st_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      op_r    <= op_nxt;
      valid_r <= valid_nxt;
    end
  end

  // next state; clear has priority over a simultaneous enter
  always_comb begin
    st_nxt = st;
    if (clear_p) begin
      st_nxt = LOAD_A;
    end else if (enter_p) begin
      unique case (st)
        LOAD_A:  st_nxt = LOAD_B;
        LOAD_B:  st_nxt = LOAD_OP;
        LOAD_OP: st_nxt = READY;
        READY:   st_nxt = LOAD_B;   // new calculation: A reloaded now
        default: st_nxt = LOAD_A;
      endcase
    end
  end

  // operand updates; B/op survive a READY->LOAD_B restart until reloaded
  always_comb begin
    a_nxt     = a_r;
    b_nxt     = b_r;
    op_nxt    = op_r;
    valid_nxt = (st_nxt == READY);
    if (clear_p) begin
      a_nxt  = '0;
      b_nxt  = '0;
      op_nxt = '0;
    end else if (enter_p) begin
      unique case (st)
        LOAD_A:  a_nxt  = sw_s2;
        LOAD_B:  b_nxt  = sw_s2;
        LOAD_OP: op_nxt = sw_s2[OPW-1:0];
        READY:   a_nxt  = sw_s2;
        default: ;
      endcase
    end
  end

  assign bus.A     = a_r;
  assign bus.B     = b_r;
  assign bus.op    = op_r;
  assign bus.valid = valid_r;
  assign bus.state = st;
endmodule
